// File: rtl/rpsc_pkg.sv
// Shared definitions for the RPSC ON sequencer: state and fault-code
// encodings, counter width and the default timeout constants.
package rpsc_pkg;

  // Width of the shared timeout counter and its largest usable value
  localparam int unsigned CNT_W   = 22;
  localparam int unsigned CNT_MAX = 32'h003F_FFFF;

  // Default timeouts in clock cycles (781.25 kHz clock)
  localparam int unsigned DEF_PERM_TIMEOUT = 781250;   // 1 s
  localparam int unsigned DEF_G2_TIMEOUT   = 2343750;  // 3 s, card timer is 2 s
  localparam int unsigned DEF_DR_TIMEOUT   = 78125;    // 100 ms
  localparam int unsigned DEF_DR_OFF_DELAY = 39063;    // 50 ms

  // Sequencer states, encoding is visible on state_o
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_PERM = 3'd1,
    ST_G2_RAMP   = 3'd2,
    ST_DR_ON     = 3'd3,
    ST_RUN       = 3'd4,
    ST_SHUTDOWN  = 3'd5,
    ST_FAULT     = 3'd6
  } state_e;

  // Latched fault causes, encoding is visible on fault_code
  typedef enum logic [2:0] {
    FC_NONE         = 3'd0,
    FC_PERM_TIMEOUT = 3'd1,
    FC_G2_TIMEOUT   = 3'd2,
    FC_PERM_LOST    = 3'd3,
    FC_DR_TIMEOUT   = 3'd4,
    FC_G2_LOST      = 3'd5,
    FC_DR_LOST      = 3'd6
  } fault_code_e;

  // G2 supply is commanded on from ramp-up through the end of the off delay
  function automatic logic g2_active(input state_e s);
    return (s == ST_G2_RAMP) || (s == ST_DR_ON) || (s == ST_RUN) ||
           (s == ST_SHUTDOWN);
  endfunction

  // Drive amp is commanded on only once G2 is confirmed good
  function automatic logic dr_active(input state_e s);
    return (s == ST_DR_ON) || (s == ST_RUN);
  endfunction

  // States in which the timeout counter advances
  function automatic logic is_timed(input state_e s);
    return (s == ST_WAIT_PERM) || (s == ST_G2_RAMP) || (s == ST_DR_ON) ||
           (s == ST_SHUTDOWN);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Saturating cycle counter shared by all timed sequencer states.
// expired rises in the last cycle before the target count is reached so the
// owning state machine leaves the state exactly target cycles after entry.
module seq_timer
  import rpsc_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] count,
  output logic             expired
);

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

  // Count up while enabled, restart on clear, stick at all-ones instead of wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != ALL_ONE)) begin
      count <= count + ONE;
    end
  end

  assign expired = (count >= (target - ONE));

endmodule

// File: rtl/rpsc_on_sequencer.sv
// RPSC power-on sequencer: obtains permission from card3, ramps the G2
// supply, enables the drive amplifier and supervises the running state.
// Any loss of permission or supply health latches a fault code; an operator
// stop performs an ordered shutdown (drive amp off, then G2 after a delay).
module rpsc_on_sequencer
  import rpsc_pkg::*;
#(
  parameter int unsigned PERM_TIMEOUT = DEF_PERM_TIMEOUT,
  parameter int unsigned G2_TIMEOUT   = DEF_G2_TIMEOUT,
  parameter int unsigned DR_TIMEOUT   = DEF_DR_TIMEOUT,
  parameter int unsigned DR_OFF_DELAY = DEF_DR_OFF_DELAY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       clear_req,
  input  logic       ground_hold_ok,
  input  logic       not_alarm2,
  input  logic       not_g2_ok,
  input  logic       not_dr_amp_ok,
  output logic       g2_ps_act,
  output logic       dr_amp_cmd,
  output logic       ready,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [2:0] state_o
);

  // Reject timeouts the 22-bit counter cannot represent, and zero timeouts
  if (PERM_TIMEOUT == 0 || PERM_TIMEOUT > CNT_MAX) begin : g_bad_perm_timeout
    $error("PERM_TIMEOUT must be within 1 .. 2^22-1");
  end
  if (G2_TIMEOUT == 0 || G2_TIMEOUT > CNT_MAX) begin : g_bad_g2_timeout
    $error("G2_TIMEOUT must be within 1 .. 2^22-1");
  end
  if (DR_TIMEOUT == 0 || DR_TIMEOUT > CNT_MAX) begin : g_bad_dr_timeout
    $error("DR_TIMEOUT must be within 1 .. 2^22-1");
  end
  if (DR_OFF_DELAY == 0 || DR_OFF_DELAY > CNT_MAX) begin : g_bad_dr_off_delay
    $error("DR_OFF_DELAY must be within 1 .. 2^22-1");
  end

  localparam logic [CNT_W-1:0] PERM_T   = PERM_TIMEOUT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] G2_T     = G2_TIMEOUT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] DR_T     = DR_TIMEOUT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] OFF_T    = DR_OFF_DELAY[CNT_W-1:0];

  state_e           state_q;
  state_e           state_nxt;
  fault_code_e      code_q;
  fault_code_e      code_nxt;

  logic             perm_ok;
  logic             g2_good;
  logic             dr_good;

  logic             tmr_clear;
  logic             tmr_enable;
  logic [CNT_W-1:0] tmr_target;
  logic [CNT_W-1:0] tmr_count_unused;
  logic             tmr_expired;

  assign perm_ok = ground_hold_ok & not_alarm2;
  assign g2_good = ~not_g2_ok;
  assign dr_good = ~not_dr_amp_ok;

  // Next-state and fault-cause selection; permission loss outranks supply
  // loss, supply loss outranks timeouts, and every fault outranks a stop
  always_comb begin
    state_nxt = state_q;
    code_nxt  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (start_req && !stop_req) begin
          state_nxt = ST_WAIT_PERM;
        end
      end
      ST_WAIT_PERM: begin
        if (perm_ok) begin
          state_nxt = stop_req ? ST_SHUTDOWN : ST_G2_RAMP;
        end else if (tmr_expired) begin
          state_nxt = ST_FAULT;
          code_nxt  = FC_PERM_TIMEOUT;
        end else if (stop_req) begin
          state_nxt = ST_SHUTDOWN;
        end
      end
      ST_G2_RAMP: begin
        if (!perm_ok) begin
          state_nxt = ST_FAULT;
          code_nxt  = FC_PERM_LOST;
        end else if (g2_good) begin
          state_nxt = stop_req ? ST_SHUTDOWN : ST_DR_ON;
        end else if (tmr_expired) begin
          state_nxt = ST_FAULT;
          code_nxt  = FC_G2_TIMEOUT;
        end else if (stop_req) begin
          state_nxt = ST_SHUTDOWN;
        end
      end
      ST_DR_ON: begin
        if (!perm_ok) begin
          state_nxt = ST_FAULT;
          code_nxt  = FC_PERM_LOST;
        end else if (!g2_good) begin
          state_nxt = ST_FAULT;
          code_nxt  = FC_G2_LOST;
        end else if (dr_good) begin
          state_nxt = stop_req ? ST_SHUTDOWN : ST_RUN;
        end else if (tmr_expired) begin
          state_nxt = ST_FAULT;
          code_nxt  = FC_DR_TIMEOUT;
        end else if (stop_req) begin
          state_nxt = ST_SHUTDOWN;
        end
      end
      ST_RUN: begin
        if (!perm_ok) begin
          state_nxt = ST_FAULT;
          code_nxt  = FC_PERM_LOST;
        end else if (!g2_good) begin
          state_nxt = ST_FAULT;
          code_nxt  = FC_G2_LOST;
        end else if (!dr_good) begin
          state_nxt = ST_FAULT;
          code_nxt  = FC_DR_LOST;
        end else if (stop_req) begin
          state_nxt = ST_SHUTDOWN;
        end
      end
      ST_SHUTDOWN: begin
        if (tmr_expired) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (clear_req && !start_req) begin
          state_nxt = ST_IDLE;
          code_nxt  = FC_NONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        code_nxt  = FC_NONE;
      end
    endcase
  end

  // Pick the timeout that applies to the current state
  always_comb begin
    tmr_target = PERM_T;
    case (state_q)
      ST_WAIT_PERM: tmr_target = PERM_T;
      ST_G2_RAMP:   tmr_target = G2_T;
      ST_DR_ON:     tmr_target = DR_T;
      ST_SHUTDOWN:  tmr_target = OFF_T;
      default:      tmr_target = PERM_T;
    endcase
  end

  assign tmr_clear  = (state_nxt != state_q);
  assign tmr_enable = is_timed(state_q);

  seq_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .target  (tmr_target),
    .count   (tmr_count_unused),
    .expired (tmr_expired)
  );

  // State register with outputs decoded from the next state, so every
  // command changes on the same edge as the state it belongs to
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      code_q     <= FC_NONE;
      g2_ps_act  <= 1'b0;
      dr_amp_cmd <= 1'b0;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      code_q     <= code_nxt;
      g2_ps_act  <= g2_active(state_nxt);
      dr_amp_cmd <= dr_active(state_nxt);
      ready      <= (state_nxt == ST_RUN);
      fault      <= (state_nxt == ST_FAULT);
    end
  end

  assign state_o    = state_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_rpsc_on_sequencer.sv
// Directed self-checking bench for the RPSC ON sequencer with short timeouts.
module tb_rpsc_on_sequencer;

  logic       clk;
  logic       reset;
  logic       start_req;
  logic       stop_req;
  logic       clear_req;
  logic       ground_hold_ok;
  logic       not_alarm2;
  logic       not_g2_ok;
  logic       not_dr_amp_ok;
  logic       g2_ps_act;
  logic       dr_amp_cmd;
  logic       ready;
  logic       fault;
  logic [2:0] fault_code;
  logic [2:0] state_o;

  int checks;
  int failures;

  rpsc_on_sequencer #(
    .PERM_TIMEOUT (20),
    .G2_TIMEOUT   (30),
    .DR_TIMEOUT   (10),
    .DR_OFF_DELAY (5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_req      (start_req),
    .stop_req       (stop_req),
    .clear_req      (clear_req),
    .ground_hold_ok (ground_hold_ok),
    .not_alarm2     (not_alarm2),
    .not_g2_ok      (not_g2_ok),
    .not_dr_amp_ok  (not_dr_amp_ok),
    .g2_ps_act      (g2_ps_act),
    .dr_amp_cmd     (dr_amp_cmd),
    .ready          (ready),
    .fault          (fault),
    .fault_code     (fault_code),
    .state_o        (state_o)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive every sequencer input at once
  task automatic applyStimulus(input logic s, input logic p, input logic c,
                               input logic gh, input logic na2,
                               input logic ng2, input logic ndr);
    start_req      = s;
    stop_req       = p;
    clear_req      = c;
    ground_hold_ok = gh;
    not_alarm2     = na2;
    not_g2_ok      = ng2;
    not_dr_amp_ok  = ndr;
  endtask

  // One comparison against a hand-computed value
  task automatic checkOutput(input string tag, input logic [7:0] obs,
                             input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Walk the sequencer to RUN with permission and both supplies reporting OK
  task automatic driveToRun();
    applyStimulus(1, 0, 0, 1, 1, 1, 1);
    tick();
    start_req = 1'b0;
    tick();
    not_g2_ok = 1'b0;
    tick();
    not_dr_amp_ok = 1'b0;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    applyStimulus(0, 0, 0, 1, 1, 1, 1);

    #12;
    checkOutput("reset_state", 8'(state_o), 8'd0);
    checkOutput("reset_g2", 8'(g2_ps_act), 8'd0);
    checkOutput("reset_dr", 8'(dr_amp_cmd), 8'd0);
    checkOutput("reset_ready", 8'(ready), 8'd0);
    checkOutput("reset_fault", 8'(fault), 8'd0);
    checkOutput("reset_code", 8'(fault_code), 8'd0);
    reset = 1'b1;
    tick();
    checkOutput("idle_hold", 8'(state_o), 8'd0);

    $display("[TB] happy path");
    start_req = 1'b1;
    tick();
    checkOutput("hp_wait_perm", 8'(state_o), 8'd1);
    checkOutput("hp_wait_g2", 8'(g2_ps_act), 8'd0);
    start_req = 1'b0;
    tick();
    checkOutput("hp_g2_ramp", 8'(state_o), 8'd2);
    checkOutput("hp_g2_on", 8'(g2_ps_act), 8'd1);
    checkOutput("hp_ramp_dr", 8'(dr_amp_cmd), 8'd0);
    repeat (24) tick();
    checkOutput("hp_still_ramp", 8'(state_o), 8'd2);
    not_g2_ok = 1'b0;
    tick();
    checkOutput("hp_dr_on", 8'(state_o), 8'd3);
    checkOutput("hp_dr_cmd", 8'(dr_amp_cmd), 8'd1);
    repeat (2) tick();
    not_dr_amp_ok = 1'b0;
    tick();
    checkOutput("hp_run", 8'(state_o), 8'd4);
    checkOutput("hp_ready", 8'(ready), 8'd1);
    checkOutput("hp_run_g2", 8'(g2_ps_act), 8'd1);
    checkOutput("hp_run_dr", 8'(dr_amp_cmd), 8'd1);

    $display("[TB] stop from RUN");
    stop_req = 1'b1;
    tick();
    checkOutput("stop_state", 8'(state_o), 8'd5);
    checkOutput("stop_dr_off", 8'(dr_amp_cmd), 8'd0);
    checkOutput("stop_g2_held", 8'(g2_ps_act), 8'd1);
    checkOutput("stop_ready", 8'(ready), 8'd0);
    stop_req       = 1'b0;
    ground_hold_ok = 1'b0;
    repeat (3) tick();
    checkOutput("sd_no_fault", 8'(state_o), 8'd5);
    ground_hold_ok = 1'b1;
    tick();
    checkOutput("sd_g2_last", 8'(g2_ps_act), 8'd1);
    tick();
    checkOutput("sd_g2_off", 8'(g2_ps_act), 8'd0);
    checkOutput("sd_idle", 8'(state_o), 8'd0);

    $display("[TB] simultaneous loss in RUN");
    driveToRun();
    checkOutput("sim_run", 8'(state_o), 8'd4);
    ground_hold_ok = 1'b0;
    not_dr_amp_ok  = 1'b1;
    tick();
    checkOutput("sim_state", 8'(state_o), 8'd6);
    checkOutput("sim_code", 8'(fault_code), 8'd3);
    checkOutput("sim_dr", 8'(dr_amp_cmd), 8'd0);
    checkOutput("sim_g2", 8'(g2_ps_act), 8'd0);
    checkOutput("sim_fault", 8'(fault), 8'd1);

    $display("[TB] clear gating");
    clear_req = 1'b1;
    start_req = 1'b1;
    tick();
    checkOutput("clr_held", 8'(state_o), 8'd6);
    checkOutput("clr_code_held", 8'(fault_code), 8'd3);
    start_req = 1'b0;
    tick();
    checkOutput("clr_idle", 8'(state_o), 8'd0);
    checkOutput("clr_code", 8'(fault_code), 8'd0);
    checkOutput("clr_fault", 8'(fault), 8'd0);
    clear_req = 1'b0;

    $display("[TB] G2 loss outranks DR loss and stop");
    driveToRun();
    checkOutput("pri_run", 8'(state_o), 8'd4);
    stop_req      = 1'b1;
    not_g2_ok     = 1'b1;
    not_dr_amp_ok = 1'b1;
    tick();
    checkOutput("pri_state", 8'(state_o), 8'd6);
    checkOutput("pri_code", 8'(fault_code), 8'd5);
    stop_req  = 1'b0;
    clear_req = 1'b1;
    tick();
    checkOutput("pri_clr", 8'(state_o), 8'd0);
    clear_req = 1'b0;

    $display("[TB] permission never granted");
    applyStimulus(1, 0, 0, 0, 1, 1, 1);
    tick();
    checkOutput("np_wait", 8'(state_o), 8'd1);
    start_req = 1'b0;
    repeat (19) tick();
    checkOutput("np_cycle19", 8'(state_o), 8'd1);
    tick();
    checkOutput("np_fault", 8'(state_o), 8'd6);
    checkOutput("np_code", 8'(fault_code), 8'd1);
    checkOutput("np_g2", 8'(g2_ps_act), 8'd0);
    checkOutput("np_dr", 8'(dr_amp_cmd), 8'd0);
    clear_req = 1'b1;
    tick();
    clear_req      = 1'b0;
    ground_hold_ok = 1'b1;

    $display("[TB] reset mid G2_RAMP");
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    tick();
    checkOutput("rst_ramp", 8'(state_o), 8'd2);
    checkOutput("rst_g2_before", 8'(g2_ps_act), 8'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_g2_async", 8'(g2_ps_act), 8'd0);
    checkOutput("rst_state_async", 8'(state_o), 8'd0);
    #1;
    reset = 1'b1;
    tick();
    checkOutput("rst_idle_after", 8'(state_o), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rpsc_on_sequencer.md
RPSC_ON_SEQUENCER -- requirements
Module: rpsc_on_sequencer

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- PERM_TIMEOUT, 781250, cycles to obtain permission (1 s).
- G2_TIMEOUT, 2343750, cycles for card G2 OK (3 s; card timer is 2 s).
- DR_TIMEOUT, 78125, cycles for drive amp OK (100 ms).
- DR_OFF_DELAY, 39063, cycles between drive-amp off and G2 off (50 ms).

REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock.
- reset, in, 1, asynchronous, active-low reset.
- start_req, in, 1, operator ON request (level).
- stop_req, in, 1, operator OFF request (level).
- clear_req, in, 1, fault acknowledge.
- ground_hold_ok, in, 1, card3 Ground_Hold_OK.
- not_alarm2, in, 1, card3 drive-side Not_Alarm.
- not_g2_ok, in, 1, card3 Not_G2_OK (active-low OK).
- not_dr_amp_ok, in, 1, card3 Not_DR_AMP_OK (active-low OK).
- g2_ps_act, out, 1, G2 PS activate command to card3.
- dr_amp_cmd, out, 1, drive amp command to card3.
- ready, out, 1, RUN state indicator.
- fault, out, 1, FAULT state indicator.
- fault_code, out, 3, latched fault cause.
- state_o, out, 3, current state encoding.

REQ-003 All inputs SHALL be synchronous to clk; all outputs SHALL be registered or decoded from registered state only.

Function
REQ-004 The state machine SHALL have states IDLE=0, WAIT_PERM=1, G2_RAMP=2, DR_ON=3, RUN=4, SHUTDOWN=5, FAULT=6.
REQ-005 The command outputs SHALL be driven per state: g2_ps_act=1 in G2_RAMP, DR_ON, RUN and in SHUTDOWN until the off delay ends; dr_amp_cmd=1 in DR_ON and RUN only; ready=1 in RUN only; fault=1 in FAULT only.
REQ-006 IDLE: start_req=1 with stop_req=0 SHALL cause the transition to WAIT_PERM; if both are high, the block SHALL stay in IDLE.
REQ-007 WAIT_PERM: ground_hold_ok=1 and not_alarm2=1 SHALL cause the transition to G2_RAMP; otherwise, at cycle PERM_TIMEOUT after entry, the block SHALL go to FAULT with code 1.
REQ-008 G2_RAMP: not_g2_ok=0 SHALL cause the transition to DR_ON; otherwise, at cycle G2_TIMEOUT after entry, the block SHALL go to FAULT with code 2.
REQ-009 DR_ON: not_dr_amp_ok=0 SHALL cause the transition to RUN; otherwise, at cycle DR_TIMEOUT after entry, the block SHALL go to FAULT with code 4.
REQ-010 The loss-of-permission codes SHALL apply as follows:
- In G2_RAMP, DR_ON and RUN, ground_hold_ok=0 or not_alarm2=0 -> FAULT with code 3 (PERM_LOST).
- In DR_ON and RUN, not_g2_ok=1 -> FAULT with code 5 (G2_LOST).
- In RUN, not_dr_amp_ok=1 -> FAULT with code 6 (DR_LOST).
REQ-011 When several fault conditions are true in the same cycle, fault priority SHALL be 3 > 5 > 6 > timeout codes.
REQ-012 Any fault SHALL override stop_req in the same cycle.
REQ-013 stop_req=1 in WAIT_PERM, G2_RAMP, DR_ON or RUN (with no fault) SHALL cause the transition to SHUTDOWN.
REQ-014 SHUTDOWN SHALL drive dr_amp_cmd=0 immediately and hold g2_ps_act=1 for DR_OFF_DELAY cycles, then go to IDLE with g2_ps_act=0.
REQ-015 Faults SHALL NOT be checked in SHUTDOWN.
REQ-016 In FAULT, g2_ps_act=0 and dr_amp_cmd=0 SHALL hold from the first FAULT cycle, and fault_code SHALL hold until exit.
REQ-017 FAULT SHALL exit to IDLE only when clear_req=1 and start_req=0; on exit, fault_code SHALL be cleared to 0.
REQ-018 A single timeout counter SHALL be zeroed on every state entry and SHALL increment each cycle while in a timed state, with no wrap.
REQ-019 The counter width SHALL be 22 bits, and elaboration SHALL fail if any parameter is 0 or exceeds 2^22-1.
REQ-020 Every input sample SHALL take effect on the following clk edge, giving 1-cycle latency to the command outputs.

Reset
REQ-021 reset=0 SHALL asynchronously force state IDLE, counter 0, g2_ps_act=0, dr_amp_cmd=0, ready=0, fault=0, fault_code=0.
REQ-022 Reset asserted mid-sequence, including during SHUTDOWN, SHALL drop both commands immediately without the off delay.

Structure
REQ-023 A shared package rpsc_pkg SHALL hold the state enum, the fault_code enum and the default timeout constants.
REQ-024 The counter SHALL be one sub-module, seq_timer (clear, enable, count, expired against a target input).

Verification
REQ-025 The bench SHALL override the parameters to PERM_TIMEOUT=20, G2_TIMEOUT=30, DR_TIMEOUT=10, DR_OFF_DELAY=5.
REQ-026 The bench SHALL cover these directed scenarios:
- Happy path: start_req=1; permission high; not_g2_ok falls 25 cycles after g2_ps_act rises; not_dr_amp_ok falls 3 cycles later -> ready=1, state_o=4.
- Permission never granted: start_req=1, ground_hold_ok=0 -> FAULT at cycle 20, fault_code=1, both commands 0.
- Simultaneous loss in RUN: ground_hold_ok=0 and not_dr_amp_ok=1 in the same cycle -> fault_code=3 and dr_amp_cmd=0 on the next edge.
- Stop from RUN: stop_req=1 -> dr_amp_cmd=0 next cycle, g2_ps_act=0 after 5 cycles, then state_o=0.
- Clear gating: clear_req=1 with start_req=1 -> stays in FAULT; start_req=0 -> IDLE with fault_code=0.
- Reset mid-G2_RAMP: reset=0 -> g2_ps_act=0 asynchronously, before the next edge.
